// File: rtl/dau_seq_arb_pkg.sv
// Shared types and constants for the DAU sequencer arbiter.
// Holds the BCDU opcode/flag widths and the arbiter FSM encoding.
package dau_seq_arb_pkg;

  localparam int BCDU_NUM_FLAGS = 4;

  localparam logic [3:0]  BCDU_OP_NOP    = 4'h0;
  localparam logic [15:0] BCDU_NOP_INSTR = {BCDU_OP_NOP, 12'b0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_WAIT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/dau_seq_arb.sv
// Arbitrates one DAU op onto one of four sequencers and relays its BCDU stream.
// Define DAU_SEQ_ARB_INSTR_CNT_EN to add the o_instr_cnt issued-instruction counter.
module dau_seq_arb
  import dau_seq_arb_pkg::*;
#(
  parameter int COMMA_POS_W = 4,
  parameter int N_SEQ       = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_op_valid,
  input  logic [1:0]                    i_op_code,
  input  logic                          i_sign_a,
  input  logic                          i_sign_b,
  input  logic [COMMA_POS_W-1:0]        i_comma_pos_a,
  input  logic [COMMA_POS_W-1:0]        i_comma_pos_b,
  input  logic [3:0]                    i_addr_a,
  input  logic [3:0]                    i_addr_b,
  output logic                          o_op_ready,
  output logic                          o_done,
  output logic                          o_sign,
  output logic [COMMA_POS_W-1:0]        o_comma_pos,
  output logic [N_SEQ-1:0]              o_seq_start,
  output logic [N_SEQ-1:0]              o_seq_accept,
  output logic                          o_sign_a,
  output logic                          o_sign_b,
  output logic [COMMA_POS_W-1:0]        o_comma_pos_a,
  output logic [COMMA_POS_W-1:0]        o_comma_pos_b,
  output logic [3:0]                    o_addr_a,
  output logic [3:0]                    o_addr_b,
  output logic [BCDU_NUM_FLAGS-1:0]     o_flags,
`ifdef DAU_SEQ_ARB_INSTR_CNT_EN
  output logic [15:0]                   o_instr_cnt,
`endif
  input  logic [N_SEQ-1:0]              i_seq_instr_valid,
  input  logic [16*N_SEQ-1:0]           i_seq_instr,
  input  logic [N_SEQ-1:0]              i_seq_ready,
  input  logic [N_SEQ-1:0]              i_seq_sign,
  input  logic [N_SEQ*COMMA_POS_W-1:0]  i_seq_comma_pos,
  output logic                          o_bcdu_instr_valid,
  output logic [15:0]                   o_bcdu_instr,
  input  logic                          i_bcdu_done,
  input  logic [BCDU_NUM_FLAGS-1:0]     i_bcdu_flags
);

  state_t state, state_nxt;

  logic [1:0] sel;
  logic       seen_busy;
  logic       last_instr;

  logic                   sel_valid;
  logic                   sel_ready;
  logic [15:0]            sel_instr;
  logic [COMMA_POS_W-1:0] sel_comma;

  assign sel_valid = i_seq_instr_valid[sel];
  assign sel_ready = i_seq_ready[sel];
  assign sel_instr = i_seq_instr[{sel, 4'b0000} +: 16];
  assign sel_comma = i_seq_comma_pos[sel*COMMA_POS_W +: COMMA_POS_W];

  always_comb begin
    state_nxt    = state;
    o_op_ready   = 1'b0;
    o_seq_start  = '0;
    o_seq_accept = '0;
    unique case (state)
      ST_IDLE: begin
        o_op_ready = 1'b1;
        if (i_op_valid) state_nxt = ST_START;
      end
      ST_START: begin
        o_seq_start[sel]  = 1'b1;
        o_seq_accept[sel] = 1'b1;
        state_nxt         = ST_RUN;
      end
      ST_RUN: begin
        o_seq_accept[sel] = 1'b1;
        if (sel_valid)
          state_nxt = ST_WAIT;
        else if (sel_ready && seen_busy)
          state_nxt = ST_FINISH;
      end
      ST_WAIT: begin
        if (i_bcdu_done)
          state_nxt = last_instr ? ST_FINISH : ST_RUN;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= ST_IDLE;
      sel                <= '0;
      seen_busy          <= 1'b0;
      last_instr         <= 1'b0;
      o_sign_a           <= 1'b0;
      o_sign_b           <= 1'b0;
      o_comma_pos_a      <= '0;
      o_comma_pos_b      <= '0;
      o_addr_a           <= '0;
      o_addr_b           <= '0;
      o_bcdu_instr_valid <= 1'b0;
      o_bcdu_instr       <= BCDU_NOP_INSTR;
      o_flags            <= '0;
      o_sign             <= 1'b0;
      o_comma_pos        <= '0;
      o_done             <= 1'b0;
    end else begin
      state              <= state_nxt;
      o_bcdu_instr_valid <= 1'b0;
      o_bcdu_instr       <= BCDU_NOP_INSTR;
      o_done             <= 1'b0;
      if (state == ST_IDLE && i_op_valid) begin
        sel           <= i_op_code;
        o_sign_a      <= i_sign_a;
        o_sign_b      <= i_sign_b;
        o_comma_pos_a <= i_comma_pos_a;
        o_comma_pos_b <= i_comma_pos_b;
        o_addr_a      <= i_addr_a;
        o_addr_b      <= i_addr_b;
        seen_busy     <= 1'b0;
        last_instr    <= 1'b0;
      end
      if (state == ST_RUN) begin
        if (!sel_ready) seen_busy <= 1'b1;
        // ready returning together with an instruction marks it as the final one
        if (sel_valid) begin
          o_bcdu_instr_valid <= 1'b1;
          o_bcdu_instr       <= sel_instr;
          if (sel_ready && seen_busy) last_instr <= 1'b1;
        end
      end
      if (state == ST_WAIT && i_bcdu_done)
        o_flags <= i_bcdu_flags;
      if (state == ST_FINISH) begin
        o_sign      <= i_seq_sign[sel];
        o_comma_pos <= sel_comma;
        o_done      <= 1'b1;
      end
    end
  end

`ifdef DAU_SEQ_ARB_INSTR_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_instr_cnt <= '0;
    else if (state == ST_IDLE && i_op_valid)
      o_instr_cnt <= '0;
    else if (o_bcdu_instr_valid && o_instr_cnt != 16'hFFFF)
      o_instr_cnt <= o_instr_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dau_seq_arb.sv
// Directed bench for dau_seq_arb: reset, mul/div ops, flags, final MOV,
// ignored inputs and reset mid-operation.
module tb_dau_seq_arb;

  localparam int CW = 4;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  logic            i_clk;
  logic            i_rst;
  logic            i_op_valid;
  logic [1:0]      i_op_code;
  logic            i_sign_a, i_sign_b;
  logic [CW-1:0]   i_comma_pos_a, i_comma_pos_b;
  logic [3:0]      i_addr_a, i_addr_b;
  logic            o_op_ready, o_done, o_sign;
  logic [CW-1:0]   o_comma_pos;
  logic [3:0]      o_seq_start, o_seq_accept;
  logic            o_sign_a, o_sign_b;
  logic [CW-1:0]   o_comma_pos_a, o_comma_pos_b;
  logic [3:0]      o_addr_a, o_addr_b;
  logic [3:0]      o_flags;
`ifdef DAU_SEQ_ARB_INSTR_CNT_EN
  logic [15:0]     o_instr_cnt;
`endif
  logic [3:0]      i_seq_instr_valid;
  logic [63:0]     i_seq_instr;
  logic [3:0]      i_seq_ready;
  logic [3:0]      i_seq_sign;
  logic [4*CW-1:0] i_seq_comma_pos;
  logic            o_bcdu_instr_valid;
  logic [15:0]     o_bcdu_instr;
  logic            i_bcdu_done;
  logic [3:0]      i_bcdu_flags;

  int n_chk, n_fail;
  int n_issue, n_done, n_start;

  dau_seq_arb #(.COMMA_POS_W(CW), .N_SEQ(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_op_valid(i_op_valid), .i_op_code(i_op_code),
    .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
    .i_comma_pos_a(i_comma_pos_a), .i_comma_pos_b(i_comma_pos_b),
    .i_addr_a(i_addr_a), .i_addr_b(i_addr_b),
    .o_op_ready(o_op_ready), .o_done(o_done),
    .o_sign(o_sign), .o_comma_pos(o_comma_pos),
    .o_seq_start(o_seq_start), .o_seq_accept(o_seq_accept),
    .o_sign_a(o_sign_a), .o_sign_b(o_sign_b),
    .o_comma_pos_a(o_comma_pos_a), .o_comma_pos_b(o_comma_pos_b),
    .o_addr_a(o_addr_a), .o_addr_b(o_addr_b),
    .o_flags(o_flags),
`ifdef DAU_SEQ_ARB_INSTR_CNT_EN
    .o_instr_cnt(o_instr_cnt),
`endif
    .i_seq_instr_valid(i_seq_instr_valid), .i_seq_instr(i_seq_instr),
    .i_seq_ready(i_seq_ready), .i_seq_sign(i_seq_sign),
    .i_seq_comma_pos(i_seq_comma_pos),
    .o_bcdu_instr_valid(o_bcdu_instr_valid), .o_bcdu_instr(o_bcdu_instr),
    .i_bcdu_done(i_bcdu_done), .i_bcdu_flags(i_bcdu_flags)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    if (o_bcdu_instr_valid) n_issue++;
    if (o_done) n_done++;
    if (|o_seq_start) n_start++;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    n_issue = 0; n_done = 0; n_start = 0;
    i_rst = 1'b1;
    i_op_valid = 1'b0; i_op_code = 2'd0;
    i_sign_a = 1'b0; i_sign_b = 1'b0;
    i_comma_pos_a = '0; i_comma_pos_b = '0;
    i_addr_a = '0; i_addr_b = '0;
    i_seq_instr_valid = '0; i_seq_instr = '0;
    i_seq_ready = 4'hF; i_seq_sign = 4'b1000;
    i_seq_comma_pos = {4'd2, 4'd7, 4'd5, 4'd3};
    i_bcdu_done = 1'b0; i_bcdu_flags = '0;

    // reset
    tick(); tick();
    check("rst_ready", o_op_ready, 1);
    check("rst_ivalid", o_bcdu_instr_valid, 0);
    check("rst_instr", o_bcdu_instr, NOP_INSTR);
    check("rst_flags", o_flags, 0);
    check("rst_done", o_done, 0);
    check("rst_start", {o_seq_start, o_seq_accept}, 0);
    i_rst = 1'b0;
    tick();

    // mul op: busy then ready with no instruction -> finish
    i_op_valid = 1'b1; i_op_code = 2'd2;
    i_sign_a = 1'b1; i_comma_pos_b = 4'd9;
    i_addr_a = 4'h5; i_addr_b = 4'hA;
    tick();
    check("mul_start", o_seq_start, 4'b0100);
    check("mul_acc_s", o_seq_accept, 4'b0100);
    check("mul_busy", o_op_ready, 0);
    check("mul_opnd", {o_sign_a, o_comma_pos_b, o_addr_a, o_addr_b},
          {1'b1, 4'd9, 4'h5, 4'hA});
    i_op_valid = 1'b0; i_seq_ready[2] = 1'b0;
    tick();
    check("mul_acc_r", {o_seq_start, o_seq_accept}, {4'b0000, 4'b0100});
    tick();
    i_seq_ready[2] = 1'b1;
    tick();
    check("mul_nodone", o_done, 0);
    tick();
    check("mul_done", o_done, 1);
    check("mul_comma", o_comma_pos, 4'd7);
    check("mul_sign", o_sign, 0);
    tick();
    check("mul_pulse", o_done, 0);

    // div op: three instructions, last is MOV with ready rising
    n_issue = 0; n_done = 0; n_start = 0;
    i_op_valid = 1'b1; i_op_code = 2'd3;
    tick();
    check("div_start", o_seq_start, 4'b1000);
    i_op_valid = 1'b0; i_seq_ready[3] = 1'b0;
    tick();
    check("div_acc_r", o_seq_accept, 4'b1000);
    i_op_valid = 1'b1;
    i_seq_instr_valid = 4'b0001; i_seq_instr[15:0] = 16'h2AAA;
    tick();
    check("ign_issue", o_bcdu_instr_valid, 0);
    check("ign_start", o_seq_start, 0);
    i_op_valid = 1'b0;
    i_seq_instr_valid = 4'b1000; i_seq_instr[63:48] = 16'h3123;
    tick();
    check("i1_valid", o_bcdu_instr_valid, 1);
    check("i1_instr", o_bcdu_instr, 16'h3123);
    check("i1_acc", o_seq_accept, 0);
    i_seq_instr_valid = '0;
    tick();
    check("i1_pulse", o_bcdu_instr_valid, 0);
    check("i1_nop", o_bcdu_instr, NOP_INSTR);
    check("i1_acc_w", o_seq_accept, 0);
    i_bcdu_done = 1'b1; i_bcdu_flags = 4'b0001;
    tick();
    check("zf_set", o_flags, 4'b0001);
    check("div_acc_r2", o_seq_accept, 4'b1000);
    i_bcdu_done = 1'b0; i_bcdu_flags = '0;
    i_seq_instr_valid = 4'b1000; i_seq_instr[63:48] = 16'h4456;
    tick();
    check("i2_instr", {o_bcdu_instr_valid, o_bcdu_instr}, {1'b1, 16'h4456});
    check("zf_hold", o_flags, 4'b0001);
    i_seq_instr_valid = '0;
    tick();
    check("zf_hold2", o_flags, 4'b0001);
    check("i2_acc_w", o_seq_accept, 0);
    i_bcdu_done = 1'b1; i_bcdu_flags = 4'b0010;
    tick();
    check("cf_set", o_flags, 4'b0010);
    i_bcdu_done = 1'b0; i_bcdu_flags = '0;
    i_seq_instr_valid = 4'b1000; i_seq_instr[63:48] = 16'h1789;
    i_seq_ready[3] = 1'b1;
    tick();
    check("mov_instr", {o_bcdu_instr_valid, o_bcdu_instr}, {1'b1, 16'h1789});
    check("mov_nodone", o_done, 0);
    i_seq_instr_valid = '0;
    tick();
    check("mov_nodone2", o_done, 0);
    i_bcdu_done = 1'b1; i_bcdu_flags = 4'b0001;
    tick();
    check("mov_nodone3", o_done, 0);
    i_bcdu_done = 1'b0; i_bcdu_flags = '0;
    tick();
    check("div_done", o_done, 1);
    check("div_comma", o_comma_pos, 4'd2);
    check("div_sign", o_sign, 1);
    check("div_ready", o_op_ready, 1);
    check("div_flags", o_flags, 4'b0001);
`ifdef DAU_SEQ_ARB_INSTR_CNT_EN
    check("div_cnt", o_instr_cnt, 3);
`endif
    tick();
    check("div_pulse", o_done, 0);
    check("div_nissue", n_issue, 3);
    check("div_ndone", n_done, 1);
    check("div_nstart", n_start, 1);
    i_bcdu_done = 1'b1; i_bcdu_flags = 4'hF;
    tick();
    check("stray_done", o_flags, 4'b0001);
    i_bcdu_done = 1'b0; i_bcdu_flags = '0;

    // reset while waiting on the BCDU
    i_op_valid = 1'b1; i_op_code = 2'd3;
    tick();
    i_op_valid = 1'b0; i_seq_ready[3] = 1'b0;
    tick();
    i_seq_instr_valid = 4'b1000; i_seq_instr[63:48] = 16'h5001;
    tick();
    check("rw_issue", o_bcdu_instr_valid, 1);
    i_seq_instr_valid = '0;
    i_rst = 1'b1;
    tick();
    check("rw_ready", o_op_ready, 1);
    check("rw_flags", o_flags, 0);
    check("rw_ivalid", o_bcdu_instr_valid, 0);
    i_rst = 1'b0;
    i_bcdu_done = 1'b1; i_bcdu_flags = 4'hF;
    tick();
    check("rw_noflags", o_flags, 0);
    check("rw_idle", o_op_ready, 1);
    i_bcdu_done = 1'b0; i_bcdu_flags = '0;
    tick();
    check("rw_nodone", o_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
